// File: rtl/term_scroll_ctrl.sv
// rtl/term_scroll_ctrl.sv - character terminal: input FIFO, CR/BS/FF engine, ring-buffer scrolling, 8x8 dot output
// Optional CURSOR_EN adds a blinking inverted cursor cell.
module term_scroll_ctrl #(
  parameter int COLS_LOG2 = 5,
  parameter int ROWS_LOG2 = 5,
  parameter int VIS_ROWS  = 28,
  parameter int FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic [10:0] char_addr,
  input  logic [7:0]  char_data,
  output logic        dot
);

  localparam int AW     = COLS_LOG2 + ROWS_LOG2;
  localparam int DEPTH  = 1 << AW;
  localparam int FDEPTH = 1 << FIFO_LOG2;
  localparam logic [ROWS_LOG2-1:0] LAST_ROW = ROWS_LOG2'(VIS_ROWS - 1);
  localparam logic [COLS_LOG2-1:0] LAST_COL = '1;
  localparam logic [AW-1:0]        LAST_ADDR = '1;
  localparam logic [9:0] H_LIMIT = 10'((1 << COLS_LOG2) * 8);
  localparam logic [9:0] V_LIMIT = 10'(VIS_ROWS * 8);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CLEAR_ROW = 2'd1,
    S_CLEAR_ALL = 2'd2
  } state_t;

  state_t state, state_n;

  // Input FIFO
  logic [6:0]           fifo_mem [FDEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG2:0]   fifo_cnt;
  logic                 fifo_empty, fifo_full, push, pop;
  logic [6:0]           ch;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (FIFO_LOG2+1)'(FDEPTH));
  assign in_ready   = !fifo_full && (state != S_CLEAR_ALL);
  assign push       = in_valid && in_ready;
  assign ch         = fifo_mem[rd_ptr];

  logic unused_in;
  assign unused_in = &{1'b0, in_data[7]};

  // Frame store and engine state
  logic [6:0]           fbuf [DEPTH];
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [6:0]           wdata;
  logic [AW-1:0]        clr_cnt, clr_n;
  logic [COLS_LOG2-1:0] cur_col, col_n, col_dec;
  logic [ROWS_LOG2-1:0] cur_row, row_n, scroll, scroll_n, phys_row;
  logic                 newline, busy_now, busy_q;

  assign phys_row = cur_row + scroll;
  assign col_dec  = cur_col - 1'b1;
  assign busy_now = !fifo_empty || (state != S_IDLE);
  // Held one extra cycle so busy covers the final buffer write.
  assign busy     = busy_now || busy_q;

  always_comb begin
    state_n  = state;
    clr_n    = clr_cnt;
    col_n    = cur_col;
    row_n    = cur_row;
    scroll_n = scroll;
    pop      = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    newline  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (ch >= 7'd32 && ch <= 7'd126) begin
            we    = 1'b1;
            waddr = {phys_row, cur_col};
            wdata = ch;
            if (cur_col == LAST_COL) newline = 1'b1;
            else                     col_n   = cur_col + 1'b1;
          end else if (ch == 7'd13) begin
            newline = 1'b1;
          end else if (ch == 7'd8) begin
            if (cur_col != '0) begin
              col_n = col_dec;
              we    = 1'b1;
              waddr = {phys_row, col_dec};
              wdata = 7'h20;
            end
          end else if (ch == 7'd12) begin
            state_n = S_CLEAR_ALL;
            clr_n   = '0;
          end
          if (newline) begin
            col_n = '0;
            if (cur_row < LAST_ROW) begin
              row_n = cur_row + 1'b1;
            end else begin
              scroll_n = scroll + 1'b1;
              state_n  = S_CLEAR_ROW;
              clr_n    = '0;
            end
          end
        end
      end
      // scroll is already advanced, so phys_row is the newly exposed row
      S_CLEAR_ROW: begin
        we    = 1'b1;
        waddr = {phys_row, clr_cnt[COLS_LOG2-1:0]};
        clr_n = clr_cnt + 1'b1;
        if (clr_cnt[COLS_LOG2-1:0] == LAST_COL) state_n = S_IDLE;
      end
      S_CLEAR_ALL: begin
        we    = 1'b1;
        waddr = clr_cnt;
        clr_n = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_n  = S_IDLE;
          scroll_n = '0;
          col_n    = '0;
          row_n    = '0;
        end
      end
      default: begin
        state_n = S_CLEAR_ALL;
        clr_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_CLEAR_ALL;
      clr_cnt  <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
      scroll   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      busy_q   <= 1'b1;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_n;
      cur_col <= col_n;
      cur_row <= row_n;
      scroll  <= scroll_n;
      busy_q  <= busy_now;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data[6:0];
    if (we)   fbuf[waddr]      <= wdata;
  end

  // Video: buffer read -> char_addr, then font bit -> dot
  logic                 vis, vis_d, cursor_inv;
  logic [2:0]           hsub_d;
  logic [ROWS_LOG2-1:0] vrow, rd_row;
  logic [COLS_LOG2-1:0] hcol;

  assign vis    = ({1'b0, hpos} < H_LIMIT) && ({1'b0, vpos} < V_LIMIT);
  assign vrow   = vpos[ROWS_LOG2+2:3];
  assign hcol   = hpos[COLS_LOG2+2:3];
  assign rd_row = vrow + scroll;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_addr <= '0;
      vis_d     <= 1'b0;
      hsub_d    <= '0;
      dot       <= 1'b0;
    end else begin
      char_addr <= {1'b0, fbuf[{rd_row, hcol}], vpos[2:0]};
      vis_d     <= vis;
      hsub_d    <= hpos[2:0];
      dot       <= vis_d && (char_data[3'd7 - hsub_d] ^ cursor_inv);
    end
  end

`ifdef CURSOR_EN
  logic [4:0] frame_cnt;
  logic       vpos_nz_q, cur_hit_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      vpos_nz_q <= 1'b0;
      cur_hit_d <= 1'b0;
    end else begin
      vpos_nz_q <= (vpos != 9'd0);
      if (vpos == 9'd0 && vpos_nz_q) frame_cnt <= frame_cnt + 1'b1;
      cur_hit_d <= frame_cnt[4] && (state != S_CLEAR_ALL) &&
                   (vrow == cur_row) && (hcol == cur_col);
    end
  end

  assign cursor_inv = cur_hit_d;
`else
  assign cursor_inv = 1'b0;
`endif

endmodule
